// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C responder.
//   state_e        : protocol FSM states
//   I2C_ADDR_W     : bus address width
//   I2C_BYTE_W     : data byte width
//   BYTES_PER_XFER : payload bytes per transfer
package i2c_pkg;

  localparam int I2C_ADDR_W     = 7;
  localparam int I2C_BYTE_W     = 8;
  localparam int BYTES_PER_XFER = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WR_BYTE,
    ACK_WR,
    RD_BYTE,
    ACK_RD,
    IGNORE
  } state_e;

  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_rw,
                                      input logic [I2C_ADDR_W-1:0] addr);
    return addr_rw[I2C_BYTE_W-1:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchroniser plus edge detector for one open-drain bus pin.
//   clk, rst : system clock, synchronous active-high reset
//   pin_i    : asynchronous pin level
//   level_o  : synchronised level
//   rise_o   : one-cycle pulse on a synchronised 0->1 transition
//   fall_o   : one-cycle pulse on a synchronised 1->0 transition
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle-bus level so reset itself never creates a START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C responder: 7-bit address match, 2-byte write into rx_data, 2-byte
// read from tx_data. SDA is only ever pulled low (open-drain via sda_oe).
//   clk, rst         : system clock (>= 8x SCL), synchronous active-high reset
//   scl_in, sda_in   : bus pin levels
//   sda_oe           : 1 = pull SDA low
//   tx_data, tx_load : read payload and its capture pulse
//   rx_data, rx_valid: last complete write payload and its update pulse
//   rd_done          : pulse after the second read byte's master-ACK clock
//   busy             : addressed transfer in progress
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ACK_ADDR | pulling SDA low for the address ACK clock
// WR_BYTE  | shifting in a write byte
// ACK_WR   | pulling SDA low for a write-byte ACK clock
// RD_BYTE  | presenting read bits on each SCL fall
// ACK_RD   | SDA released, sampling master ACK/NACK
// IGNORE   | not addressed or transfer finished, wait for START/STOP
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h27,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] tx_data,
  output logic        tx_load,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rd_done,
  output logic        busy
);

  localparam logic LAST_BYTE = 1'(BYTES_PER_XFER - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .pin_i(scl_in),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .pin_i(sda_in),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

  state_e                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic                    byte_cnt_q, byte_cnt_d;
  logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
  logic [I2C_BYTE_W-1:0]   rx_hi_q, rx_hi_d;
  logic [15:0]             tx_shift_q, tx_shift_d;
  logic                    rw_q, rw_d;
  logic                    ack_q, ack_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    busy_q, busy_d;
  logic [15:0]             rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_load_q, tx_load_d;
  logic                    rd_done_q, rd_done_d;
  logic [I2C_BYTE_W-1:0]   byte_in;

  assign byte_in = {shift_q[I2C_BYTE_W-2:0], sda_lvl};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= 1'b0;
      shift_q    <= '0;
      rx_hi_q    <= '0;
      tx_shift_q <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rx_hi_q    <= rx_hi_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      rd_done_q  <= rd_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rx_hi_d    = rx_hi_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    rd_done_d  = 1'b0;

    if (start_c) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else if (stop_c) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: sda_oe_d = 1'b0;

        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (addr_match(byte_in, SLAVE_ADDR)) begin
                busy_d  = 1'b1;
                rw_d    = sda_lvl;
                state_d = ACK_ADDR;
                if (sda_lvl) begin
                  tx_shift_d = tx_data;
                  tx_load_d  = 1'b1;
                end
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        // sda_oe doubles as the phase flag: the first fall starts the ACK
        // clock, the second fall ends it.
        ACK_ADDR: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              state_d    = RD_BYTE;
              sda_oe_d   = ~tx_shift_q[15];
              tx_shift_d = {tx_shift_q[14:0], 1'b0};
              bit_cnt_d  = '0;
            end else begin
              state_d   = WR_BYTE;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end

        WR_BYTE: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              state_d   = ACK_WR;
            end
          end
        end

        ACK_WR: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (byte_cnt_q == LAST_BYTE) begin
                state_d    = IGNORE;
                rx_data_d  = {rx_hi_q, shift_q};
                rx_valid_d = 1'b1;
              end else begin
                state_d    = WR_BYTE;
                rx_hi_d    = shift_q;
                byte_cnt_d = 1'b1;
              end
            end
          end
        end

        // Bit 0 of each byte is presented on entry; this counts the rest.
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ACK_RD;
            end else begin
              sda_oe_d   = ~tx_shift_q[15];
              tx_shift_d = {tx_shift_q[14:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 3'd1;
            end
          end
        end

        ACK_RD: begin
          if (scl_rise) begin
            ack_d = ~sda_lvl;
          end else if (scl_fall) begin
            if (ack_q && byte_cnt_q != LAST_BYTE) begin
              state_d    = RD_BYTE;
              byte_cnt_d = 1'b1;
              bit_cnt_d  = '0;
              sda_oe_d   = ~tx_shift_q[15];
              tx_shift_d = {tx_shift_q[14:0], 1'b0};
            end else begin
              state_d   = IGNORE;
              sda_oe_d  = 1'b0;
              rd_done_d = (byte_cnt_q == LAST_BYTE);
            end
          end
        end

        IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign rd_done  = rd_done_q;

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Responder end of the team's I2C link.
- Samples the open-drain SCL/SDA pins on the system clock and detects START/STOP.
- Matches a 7-bit address; on a write it receives two data bytes, on a read it returns two bytes. It drives ACK and read data on SDA by pulling low only.
- Sits on the bus opposite the team's I2C master/driver and hands the 16-bit payload to local logic.

Parameters:
- SLAVE_ADDR, 7'h27, 7-bit bus address this block answers to.
- SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  SCL pin level (never driven by this block).
- sda_in  input  1  SDA pin level.
- sda_oe  output  1  1 = pull SDA low, 0 = release (pad is open-drain).
- tx_data  input  16  read payload; [15:8] is sent first, MSB first.
- tx_load  output  1  one-cycle pulse when tx_data is captured for a read.
- rx_data  output  16  last complete write payload; first byte in [15:8].
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rd_done  output  1  one-cycle pulse at the end of the second read byte's master-ACK clock.
- busy  output  1  high from an address-matched START until STOP or return to IDLE.

Behaviour:
- Reset: on rst=1 at a clk edge, state=IDLE and sda_oe, tx_load, rx_valid, rd_done, busy are all 0. rx_data=16'h0000; bit and byte counters are 0. Reset mid-transfer releases SDA on the following cycle.
- Input path: SYNC_STAGES-flop synchroniser, then one registered copy for edge detect.
  - scl_rise/scl_fall/sda_rise/sda_fall are valid SYNC_STAGES+1 clk after a pin change.
- Bus conditions:
  - START = sda_fall while synchronised SCL is high.
  - STOP = sda_rise while synchronised SCL is high.
  - START/STOP take priority over any SCL edge in the same cycle and are honoured in every state, including a repeated START.
  - START -> ADDR with counters cleared and sda_oe=0.
  - STOP -> IDLE with sda_oe=0 and busy=0.
- Sampling rules: sample SDA on scl_rise; change sda_oe only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on scl_rise (7 address bits MSB first, then R/W).
    - After bit 8, on a match the block sets busy=1 and goes to ACK_ADDR. If R/W=1 it also latches tx_data and pulses tx_load.
    - On a mismatch -> IGNORE.
  - ACK_ADDR: sda_oe=1 at the next scl_fall and held through the 9th clock.
    - At the following scl_fall: write -> WR_BYTE with sda_oe=0; read -> RD_BYTE with sda_oe=~tx_shift[15].
  - WR_BYTE: shift 8 bits on scl_rise -> ACK_WR.
  - ACK_WR: ACK the byte exactly as in ACK_ADDR.
    - After byte 0, release and go to WR_BYTE.
    - After byte 1, rx_valid pulses and rx_data is updated in the clk after the ACK-ending scl_fall; then -> IGNORE.
    - A third byte is therefore not ACKed.
  - RD_BYTE: on each scl_fall present the next bit via sda_oe=~bit; after the 8th bit's scl_fall, sda_oe=0 and -> ACK_RD.
  - ACK_RD: sample master ACK on scl_rise, act at scl_fall.
    - ACK (sda=0) with byte 0 done -> RD_BYTE on the low byte.
    - NACK, or byte 1 done -> IGNORE with sda_oe=0.
    - rd_done pulses on the second-byte ACK_RD exit whether the master ACKed or NACKed.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Incomplete writes: a write aborted by STOP/START before byte 1's ACK never pulses rx_valid; rx_data keeps its old value.
- SDA release: sda_oe is never asserted in IDLE, ADDR, WR_BYTE or IGNORE.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ACK_ADDR, WR_BYTE, ACK_WR, RD_BYTE, ACK_RD, IGNORE);
  - I2C_ADDR_W=7, I2C_BYTE_W=8, BYTES_PER_XFER=2.
- Sub-module i2c_sync_edge: synchroniser plus edge detect for one pin. Instantiated twice; outputs level, rise, fall.

Test Plan:
- Write to 0x27 with 8'hA5, 8'h3C, then STOP -> ACK on the address and both bytes; a single rx_valid pulse with rx_data=16'hA53C; busy returns to 0 after STOP.
- Read from 0x27 with tx_data=16'hBEEF, master ACKs then NACKs -> tx_load pulses once; SDA carries 8'hBE then 8'hEF MSB first; rd_done pulses once; sda_oe=0 after the final NACK.
- Address 0x26, write -> no ACK (sda_oe stays 0), busy stays 0, no rx_valid; the next transfer to 0x27 works normally.
- Write 0x27 with byte 8'h11 then a repeated START and a write of 8'h22, 8'h33 -> no rx_valid for the aborted frame; rx_data=16'h2233 after the second frame.
- rst=1 for one clk while sda_oe=1 during an address ACK -> sda_oe=0 next cycle; state is IDLE; the following START/0x27 write completes.
- Write 0x27 with three bytes 8'h01, 8'h02, 8'h03 -> rx_data=16'h0102, the third byte is NACKed, and rx_valid pulses exactly once.
